// File: rtl/afu_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afu_pll_pkg
// Description : Shared state encoding, default constants and helpers for the
//               AFU PLL supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
package afu_pll_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int unsigned c_pll_rst_cycles = 16;
  localparam int unsigned c_lock_timeout   = 4096;
  localparam int unsigned c_settle_cycles  = 256;
  localparam int unsigned c_max_retries    = 3;
  localparam int unsigned c_meas_window    = 1024;

  // Heartbeat edge counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/afu_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : afu_bit_sync
// Description : Two-flop synchronizer with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module afu_bit_sync (
  input  logic clk,
  input  logic resetb,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/afu_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : afu_pll_supervisor
// Description : Sequences PLL reset/lock/settle, releases the AFU reset and
//               measures the PLL heartbeat rate while running.
// Revision    : 1.0 - initial release
// ============================================================================
module afu_pll_supervisor
  import afu_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = c_pll_rst_cycles,
  parameter int unsigned LOCK_TIMEOUT   = c_lock_timeout,
  parameter int unsigned SETTLE_CYCLES  = c_settle_cycles,
  parameter int unsigned MAX_RETRIES    = c_max_retries,
  parameter int unsigned MEAS_WINDOW    = c_meas_window
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        pll_locked,
  input  logic        pll_hb,
  output logic        pll_rst,
  output logic        afu_resetb,
  output logic        lock_lost,
  output logic        pll_fail,
  output logic [1:0]  retry_cnt,
  output logic [15:0] hb_count,
  output logic        hb_valid,
  output logic [2:0]  state
);

  // One timer serves the reset pulse, the lock timeout and the settle count.
  localparam int unsigned c_tmax1  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned c_tmax   = (c_tmax1 > SETTLE_CYCLES) ? c_tmax1 : SETTLE_CYCLES;
  localparam int unsigned c_tw     = $clog2(c_tmax + 1);
  localparam int unsigned c_ww     = $clog2(MEAS_WINDOW + 1);

  localparam logic [c_tw-1:0] c_t_one       = c_tw'(1);
  localparam logic [c_tw-1:0] c_rst_last    = c_tw'(PLL_RST_CYCLES - 1);
  localparam logic [c_tw-1:0] c_to_last     = c_tw'(LOCK_TIMEOUT - 1);
  localparam logic [c_tw-1:0] c_settle_last = c_tw'(SETTLE_CYCLES - 1);
  localparam logic [c_ww-1:0] c_w_one       = c_ww'(1);
  localparam logic [c_ww-1:0] c_win_last    = c_ww'(MEAS_WINDOW - 1);

  logic w_lock_s;
  logic w_hb_s;

  afu_bit_sync u_sync_lock (
    .clk    (clk),
    .resetb (resetb),
    .i_d    (pll_locked),
    .o_q    (w_lock_s)
  );

  afu_bit_sync u_sync_hb (
    .clk    (clk),
    .resetb (resetb),
    .i_d    (pll_hb),
    .o_q    (w_hb_s)
  );

  state_e          r_state;
  logic [c_tw-1:0] r_timer;
  logic [1:0]      r_retry;
  logic            r_pll_rst;
  logic            r_afu_resetb;
  logic            r_lock_lost;
  logic            r_pll_fail;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= ST_RST_PLL;
      r_timer      <= '0;
      r_retry      <= '0;
      r_pll_rst    <= 1'b1;
      r_afu_resetb <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_pll_fail   <= 1'b0;
    end else begin
      case (r_state)
        ST_RST_PLL: begin
          if (r_timer == c_rst_last) begin
            r_state   <= ST_WAIT_LOCK;
            r_timer   <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_timer <= r_timer + c_t_one;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so it wins over a coincident timeout.
          if (w_lock_s) begin
            r_state <= ST_SETTLE;
            r_timer <= '0;
          end else if (r_timer == c_to_last) begin
            r_timer   <= '0;
            r_pll_rst <= 1'b1;
            if (32'(r_retry) < MAX_RETRIES) begin
              r_retry <= r_retry + 2'd1;
              r_state <= ST_RST_PLL;
            end else begin
              r_state    <= ST_FAIL;
              r_pll_fail <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + c_t_one;
          end
        end
        ST_SETTLE: begin
          if (!w_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_timer <= '0;
          end else if (r_timer == c_settle_last) begin
            r_state      <= ST_RUN;
            r_timer      <= '0;
            r_retry      <= '0;
            r_afu_resetb <= 1'b1;
          end else begin
            r_timer <= r_timer + c_t_one;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            r_state      <= ST_RST_PLL;
            r_timer      <= '0;
            r_pll_rst    <= 1'b1;
            r_afu_resetb <= 1'b0;
            r_lock_lost  <= 1'b1;
          end
        end
        ST_FAIL: begin
          r_pll_rst    <= 1'b1;
          r_afu_resetb <= 1'b0;
          r_pll_fail   <= 1'b1;
        end
        default: begin
          r_state      <= ST_RST_PLL;
          r_timer      <= '0;
          r_pll_rst    <= 1'b1;
          r_afu_resetb <= 1'b0;
        end
      endcase
    end
  end

  logic            r_hb_prev;
  logic [c_ww-1:0] r_win;
  logic [15:0]     r_edges;
  logic [15:0]     r_hb_count;
  logic            r_hb_valid;
  logic            w_meas;
  logic            w_edge;
  logic [15:0]     w_edges_next;

  // A cycle that drops lock in RUN is already leaving, so it aborts the window.
  assign w_meas       = (r_state == ST_RUN) && w_lock_s;
  assign w_edge       = w_hb_s ^ r_hb_prev;
  assign w_edges_next = sat_inc16(r_edges, w_edge);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_hb_prev  <= 1'b0;
      r_win      <= '0;
      r_edges    <= '0;
      r_hb_count <= '0;
      r_hb_valid <= 1'b0;
    end else begin
      r_hb_prev  <= w_hb_s;
      r_hb_valid <= 1'b0;
      if (w_meas) begin
        if (r_win == c_win_last) begin
          r_hb_count <= w_edges_next;
          r_hb_valid <= 1'b1;
          r_win      <= '0;
          r_edges    <= '0;
        end else begin
          r_win   <= r_win + c_w_one;
          r_edges <= w_edges_next;
        end
      end else begin
        r_win   <= '0;
        r_edges <= '0;
      end
    end
  end

  assign pll_rst    = r_pll_rst;
  assign afu_resetb = r_afu_resetb;
  assign lock_lost  = r_lock_lost;
  assign pll_fail   = r_pll_fail;
  assign retry_cnt  = r_retry;
  assign hb_count   = r_hb_count;
  assign hb_valid   = r_hb_valid;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_afu_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_afu_pll_supervisor
// Description : Directed self-checking bench for afu_pll_supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afu_pll_supervisor;

  logic        clk        = 1'b0;
  logic        resetb     = 1'b1;
  logic        pll_locked = 1'b0;
  logic        pll_hb     = 1'b0;
  logic        pll_rst;
  logic        afu_resetb;
  logic        lock_lost;
  logic        pll_fail;
  logic [1:0]  retry_cnt;
  logic [15:0] hb_count;
  logic        hb_valid;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hb_div   = 0;
  bit hb_en    = 1'b0;

  afu_pll_supervisor dut (
    .clk        (clk),
    .resetb     (resetb),
    .pll_locked (pll_locked),
    .pll_hb     (pll_hb),
    .pll_rst    (pll_rst),
    .afu_resetb (afu_resetb),
    .lock_lost  (lock_lost),
    .pll_fail   (pll_fail),
    .retry_cnt  (retry_cnt),
    .hb_count   (hb_count),
    .hb_valid   (hb_valid),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Heartbeat toggles every 4 clocks while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (hb_en) begin
        hb_div = hb_div + 1;
        if (hb_div == 4) begin
          pll_hb = ~pll_hb;
          hb_div = 0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input string tag);
    resetb = 1'b0;
    #1;
    check_val({tag, "_vec"}, 32'({state, pll_rst, afu_resetb, lock_lost, pll_fail, retry_cnt, hb_valid}),
              32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}));
    check_val({tag, "_hbcnt"}, 32'(hb_count), 32'd0);
    step();
    step();
    resetb = 1'b1;
    cyc    = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (hb_valid !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    if (hb_valid !== 1'b1) check_val(tag, 32'(hb_valid), 32'd1);
  endtask

  initial begin
    int x;
    int rst_hi;
    bit vseen;
    bit afu_seen;

    // Nominal bring-up: lock at cycle 40, AFU released at 299
    do_reset("rst0");
    check_val("c0_state", 32'(state), 32'd0);
    check_val("c0_pll_rst", 32'(pll_rst), 32'd1);
    step_to(15);
    check_val("c15_pll_rst", 32'(pll_rst), 32'd1);
    step_to(16);
    check_val("c16_pll_rst", 32'(pll_rst), 32'd0);
    check_val("c16_state", 32'(state), 32'd1);
    step_to(40);
    pll_locked = 1'b1;
    hb_en      = 1'b1;
    step_to(42);
    check_val("c42_state", 32'(state), 32'd1);
    step_to(43);
    check_val("c43_state", 32'(state), 32'd2);
    step_to(298);
    check_val("c298_afu", 32'(afu_resetb), 32'd0);
    step_to(299);
    check_val("c299_afu", 32'(afu_resetb), 32'd1);
    check_val("c299_state", 32'(state), 32'd3);
    check_val("c299_retry", 32'(retry_cnt), 32'd0);

    // Heartbeat measurement
    wait_valid("hb_v1_timeout");
    check_val("hb_v1_cyc", 32'(cyc), 32'd1323);
    check_val("hb_v1_cnt", 32'(hb_count), 32'd256);
    step();
    check_val("hb_v1_pulse", 32'(hb_valid), 32'd0);
    wait_valid("hb_v2_timeout");
    check_val("hb_v2_cyc", 32'(cyc), 32'd2347);
    check_val("hb_v2_cnt", 32'(hb_count), 32'd256);
    hb_en = 1'b0;
    step();
    wait_valid("hb_v3_timeout");
    step();
    wait_valid("hb_v4_timeout");
    check_val("hb_hold_cnt", 32'(hb_count), 32'd0);
    hb_en = 1'b1;
    step();
    wait_valid("hb_v5_timeout");
    step();
    wait_valid("hb_v6_timeout");
    check_val("hb_resume_cnt", 32'(hb_count), 32'd256);

    // Lock loss in RUN
    x = cyc + 50;
    step_to(x);
    pll_locked = 1'b0;
    step_to(x + 2);
    check_val("ll_afu_before", 32'(afu_resetb), 32'd1);
    step_to(x + 3);
    check_val("ll_afu", 32'(afu_resetb), 32'd0);
    check_val("ll_lost", 32'(lock_lost), 32'd1);
    check_val("ll_state", 32'(state), 32'd0);
    rst_hi = int'(pll_rst);
    vseen  = 1'b0;
    while (cyc < x + 40) begin
      step();
      if (cyc == x + 30) pll_locked = 1'b1;
      rst_hi += int'(pll_rst);
      if (hb_valid) vseen = 1'b1;
    end
    check_val("ll_rst_len", 32'(rst_hi), 32'd16);
    check_val("ll_no_valid", 32'(vseen), 32'd0);
    check_val("ll_hb_hold", 32'(hb_count), 32'd256);
    step_to(x + 288);
    check_val("rl_afu_before", 32'(afu_resetb), 32'd0);
    step_to(x + 289);
    check_val("rl_afu", 32'(afu_resetb), 32'd1);
    check_val("rl_lost_sticky", 32'(lock_lost), 32'd1);
    check_val("rl_state", 32'(state), 32'd3);

    // Reset mid-window, lock held: sequence repeats
    step_to(x + 589);
    do_reset("rst_mid");
    step_to(16);
    check_val("rm_c16_state", 32'(state), 32'd1);
    step_to(17);
    check_val("rm_c17_state", 32'(state), 32'd2);
    step_to(272);
    check_val("rm_c272_afu", 32'(afu_resetb), 32'd0);
    step_to(273);
    check_val("rm_c273_afu", 32'(afu_resetb), 32'd1);
    check_val("rm_lost", 32'(lock_lost), 32'd0);

    // Lock dropout during SETTLE
    pll_locked = 1'b0;
    do_reset("rst_settle");
    step_to(40);
    pll_locked = 1'b1;
    step_to(141);
    pll_locked = 1'b0;
    step_to(143);
    check_val("sd_c143_state", 32'(state), 32'd2);
    step_to(144);
    check_val("sd_c144_state", 32'(state), 32'd1);
    check_val("sd_retry", 32'(retry_cnt), 32'd0);
    step_to(146);
    pll_locked = 1'b1;
    step_to(404);
    check_val("sd_c404_afu", 32'(afu_resetb), 32'd0);
    step_to(405);
    check_val("sd_c405_afu", 32'(afu_resetb), 32'd1);

    // Lock coinciding with the first timeout
    pll_locked = 1'b0;
    do_reset("rst_tie");
    step_to(4109);
    pll_locked = 1'b1;
    step_to(4111);
    check_val("tie_c4111_state", 32'(state), 32'd1);
    step_to(4112);
    check_val("tie_c4112_state", 32'(state), 32'd2);
    check_val("tie_retry", 32'(retry_cnt), 32'd0);

    // Never locks: retries exhausted
    pll_locked = 1'b0;
    hb_en      = 1'b0;
    do_reset("rst_fail");
    rst_hi   = int'(pll_rst);
    afu_seen = 1'b0;
    while (cyc < 16448) begin
      step();
      rst_hi += int'(pll_rst);
      if (afu_resetb) afu_seen = 1'b1;
      if (cyc == 4111)  check_val("f_c4111_retry", 32'(retry_cnt), 32'd0);
      if (cyc == 4112)  check_val("f_c4112_retry", 32'(retry_cnt), 32'd1);
      if (cyc == 8224)  check_val("f_c8224_retry", 32'(retry_cnt), 32'd2);
      if (cyc == 12336) check_val("f_c12336_retry", 32'(retry_cnt), 32'd3);
      if (cyc == 16447) check_val("f_c16447_state", 32'(state), 32'd1);
    end
    check_val("f_state", 32'(state), 32'd4);
    check_val("f_pll_fail", 32'(pll_fail), 32'd1);
    check_val("f_pll_rst", 32'(pll_rst), 32'd1);
    check_val("f_rst_cycles", 32'(rst_hi), 32'd65);
    check_val("f_afu_never", 32'(afu_seen), 32'd0);
    pll_locked = 1'b1;
    step_to(16470);
    check_val("f_stuck_state", 32'(state), 32'd4);
    check_val("f_stuck_afu", 32'(afu_resetb), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/afu_pll_supervisor.md
AFU_PLL_SUPERVISOR -- requirements
Module: afu_pll_supervisor

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and resetb.
REQ-002 Parameter PLL_RST_CYCLES, default 16: length of the PLL reset pulse, in clk cycles.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: maximum wait for lock, in clk cycles.
REQ-004 Parameter SETTLE_CYCLES, default 256: number of consecutive locked cycles required before the AFU domain is released.
REQ-005 Parameter MAX_RETRIES, default 3: number of PLL re-reset attempts after a timeout.
REQ-006 Parameter MEAS_WINDOW, default 1024: frequency-measurement window, in clk cycles.
REQ-007 Ports SHALL be (name, direction, width, meaning):
clk  in  1  reference clock; also the PLL refclk.
resetb  in  1  async active-low reset.
pll_locked  in  1  PLL lock, asynchronous to clk.
pll_hb  in  1  heartbeat toggle generated in the PLL output domain, asynchronous to clk.
pll_rst  out  1  active-high PLL reset.
afu_resetb  out  1  active-low reset for logic clocked by the PLL output.
lock_lost  out  1  sticky flag: lock dropped while in RUN.
pll_fail  out  1  sticky flag: retries exhausted.
retry_cnt  out  2  count of timeout retries.
hb_count  out  16  heartbeat edges counted in the last window.
hb_valid  out  1  one-cycle pulse when hb_count updates.
state  out  3  current FSM state.

Function
REQ-008 pll_locked and pll_hb SHALL each pass through a 2-flop synchronizer (outputs lock_s and hb_s), giving 2 cycles of latency.
REQ-009 The FSM SHALL have exactly five states: RST_PLL, WAIT_LOCK, SETTLE, RUN and FAIL.
REQ-010 RST_PLL: pll_rst=1 for PLL_RST_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK with its timer cleared.
REQ-011 WAIT_LOCK: on the first cycle with lock_s=1, the FSM SHALL go to SETTLE with the settle counter at 0.
REQ-012 WAIT_LOCK timeout: when the timer reaches LOCK_TIMEOUT-1 and retry_cnt<MAX_RETRIES, the block SHALL increment retry_cnt and go to RST_PLL; otherwise it SHALL go to FAIL.
REQ-013 If lock_s=1 arrives in the same cycle as the timeout, lock SHALL win.
REQ-014 SETTLE: if lock_s=0 in any cycle, the FSM SHALL return to WAIT_LOCK without changing retry_cnt, and the timer SHALL restart.
REQ-015 SETTLE: when the counter equals SETTLE_CYCLES-1 with lock_s=1, the FSM SHALL go to RUN and register afu_resetb<=1; afu_resetb therefore rises SETTLE_CYCLES+3 cycles after pll_locked rises.
REQ-016 On entry to RUN, retry_cnt SHALL clear to 0.
REQ-017 RUN: if lock_s=0, the block SHALL register afu_resetb<=0, set lock_lost=1 and go to RST_PLL.
REQ-018 FAIL: pll_rst=1, afu_resetb=0 and pll_fail=1; the only exit SHALL be resetb.
REQ-019 pll_rst SHALL be registered and equal 1 exactly when state is RST_PLL or FAIL.
REQ-020 Measurement SHALL run in RUN only: a window counter counts MEAS_WINDOW cycles, and an edge counter counts cycles in which hb_s differs from its previous value.
REQ-021 The edge counter SHALL saturate at 0xFFFF.
REQ-022 At the last cycle of each window, the block SHALL set hb_count<=edge count, pulse hb_valid for 1 cycle, and clear both counters.
REQ-023 An edge that coincides with the window's last cycle SHALL be included in that window.
REQ-024 Leaving RUN SHALL abort the current window without a hb_valid pulse; hb_count SHALL hold its last value.
REQ-025 lock_lost and pll_fail SHALL clear only on resetb.

Reset
REQ-026 While resetb=0, all outputs SHALL take these values immediately (asynchronous): pll_rst=1, afu_resetb=0, lock_lost=0, pll_fail=0, retry_cnt=0, hb_count=0, hb_valid=0, state=RST_PLL.
REQ-027 While resetb=0, the synchronizer flops and all counters SHALL be 0.
REQ-028 After resetb rises, the block SHALL spend cycles 0..PLL_RST_CYCLES-1 in RST_PLL.
REQ-029 Reset asserted mid-operation SHALL abort any state or window with no residual effect.

Structure
REQ-030 Package afu_pll_pkg SHALL hold the state enum (3-bit encoding) and the default parameter constants.
REQ-031 Sub-module afu_bit_sync (a 2-flop synchronizer with async active-low reset) SHALL be instantiated twice, once for pll_locked and once for pll_hb.

Verification
REQ-032 pll_locked rises at cycle 40 and holds -> pll_rst=1 for cycles 0-15; afu_resetb=1 at cycle 299; retry_cnt=0.
REQ-033 pll_locked held at 0 -> 4 pll_rst pulses of 16 cycles each; retry_cnt goes 1,2,3; FAIL and pll_fail=1 after 4*(16+4096) cycles; afu_resetb stays 0.
REQ-034 Lock drops for 5 cycles at settle count 100 -> return to WAIT_LOCK with retry_cnt unchanged; afu_resetb rises 259 cycles after lock returns.
REQ-035 Lock drops in RUN -> afu_resetb=0 within 3 cycles; lock_lost=1 (sticky); 16-cycle pll_rst pulse; re-lock yields RUN with lock_lost still 1.
REQ-036 pll_hb toggles every 4 cycles in RUN -> hb_count=256 with a hb_valid pulse every 1024 cycles; holding pll_hb -> hb_count=0.
REQ-037 resetb asserted mid-window in RUN -> outputs return to reset values in the same cycle; after release the full sequence repeats.
